// File: rtl/dac_spi_pkg.sv
// Shared definitions for the DAC SPI transmitter.
// Contents: FSM state enum, frame length, bit positions of the four
// configuration bits that head every frame, and a frame builder.
package dac_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2,
    LDAC  = 2'd3
  } state_t;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned SAMPLE_BITS = FRAME_BITS - 4;

  // Positions inside the 4-bit configuration nibble (frame bits [15:12]).
  localparam int unsigned CFG_AB_BIT   = 3; // 0 = channel A, 1 = channel B
  localparam int unsigned CFG_BUF_BIT  = 2; // 1 = buffered reference input
  localparam int unsigned CFG_GA_BIT   = 1; // 1 = gain 1x, 0 = gain 2x
  localparam int unsigned CFG_SHDN_BIT = 0; // 1 = output active

  function automatic logic [3:0] cfg_word(input logic ab, input logic buffered,
                                          input logic ga, input logic shdn);
    logic [3:0] w;
    w = '0;
    w[CFG_AB_BIT]   = ab;
    w[CFG_BUF_BIT]  = buffered;
    w[CFG_GA_BIT]   = ga;
    w[CFG_SHDN_BIT] = shdn;
    return w;
  endfunction

  // Channel A, unbuffered, gain 1x, active -> 4'b0011.
  localparam logic [3:0] CFG_DEFAULT = cfg_word(1'b0, 1'b0, 1'b1, 1'b1);

  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [3:0] cfg,
                                                        input logic [SAMPLE_BITS-1:0] sample);
    return {cfg, sample};
  endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// SCLK generator for the DAC SPI transmitter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : half-period counter runs (SHIFT and HOLD)
//   toggle     : SCLK may toggle (SHIFT only); when low SCLK is forced low
//   tick       : last cycle of the current half-period
//   rise, fall : SCLK will rise / fall on the coming clk edge
//   sclk       : registered SPI clock, mode 0
module dac_sclk_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic toggle,
  output logic tick,
  output logic rise,
  output logic fall,
  output logic sclk
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] hcnt;

  assign tick = run && (hcnt == LAST);
  assign rise = tick && toggle && !sclk;
  assign fall = tick && toggle && sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      sclk <= 1'b0;
    end else begin
      if (!run || tick) hcnt <= '0;
      else              hcnt <= hcnt + 8'd1;

      if (!toggle)   sclk <= 1'b0;
      else if (tick) sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// DAC SPI transmitter: takes samples from a valid/ready stream and sends
// 16-bit frames {CFG_BITS, sample} MSB first, SPI mode 0.
// Build option: define DAC_SPI_LDAC_EN to add an LDAC state that pulses
// dac_ldac_n low after each frame; otherwise dac_ldac_n is tied low and the
// DAC latches on the rising edge of dac_cs_n.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   s_data, s_valid     : sample stream input
//   s_ready             : registered, high only in IDLE
//   dac_cs_n, dac_sclk  : chip select (active-low), SPI clock
//   dac_mosi            : serial data
//   dac_ldac_n          : latch strobe (active-low)
//   frame_done          : one-cycle pulse in the last cycle of a frame
module dac_spi_tx
  import dac_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned AMP_WIDTH   = 12,
  parameter logic [3:0]  CFG_BITS    = CFG_DEFAULT,
  parameter int unsigned LDAC_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AMP_WIDTH-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 dac_cs_n,
  output logic                 dac_sclk,
  output logic                 dac_mosi,
  output logic                 dac_ldac_n,
  output logic                 frame_done
);

  if (CLK_DIV == 0 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("dac_spi_tx: CLK_DIV must be 1..255");
  end
  if (LDAC_CYCLES == 0 || LDAC_CYCLES > 15) begin : g_bad_ldac_cycles
    $error("dac_spi_tx: LDAC_CYCLES must be 1..15");
  end

  state_t                 state, state_n;
  logic [4:0]             ecnt, ecnt_n;
  logic [FRAME_BITS-1:0]  shreg, shreg_n;
  logic [SAMPLE_BITS-1:0] sample;
  logic                   accept;
  logic                   run, toggle, tick, rise, fall;

`ifdef DAC_SPI_LDAC_EN
  localparam logic [3:0] LDAC_LAST = 4'(LDAC_CYCLES - 1);
  logic [3:0] lcnt, lcnt_n;
`endif

  assign sample   = SAMPLE_BITS'(s_data);
  assign accept   = s_valid && s_ready;
  assign run      = (state == SHIFT) || (state == HOLD);
  assign toggle   = (state == SHIFT);
  // The shift register MSB is the data pin, so MOSI is a flop output.
  assign dac_mosi = shreg[FRAME_BITS-1];

  dac_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .toggle (toggle),
    .tick   (tick),
    .rise   (rise),
    .fall   (fall),
    .sclk   (dac_sclk)
  );

  always_comb begin
    state_n = state;
    ecnt_n  = ecnt;
    shreg_n = shreg;
`ifdef DAC_SPI_LDAC_EN
    lcnt_n  = lcnt;
`endif
    case (state)
      IDLE: begin
        shreg_n = '0;
        if (accept) begin
          shreg_n = build_frame(CFG_BITS, sample);
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        // ecnt counts completed half-periods; the 32nd ends SHIFT.
        if (rise || fall) begin
          if (ecnt == 5'd31) begin
            state_n = HOLD;
            ecnt_n  = '0;
          end else begin
            ecnt_n = ecnt + 5'd1;
          end
        end
        // Final falling edge coincides with cs_n rising; bit 0 is kept one
        // more cycle for hold time, then HOLD clears the register.
        if (fall && ecnt != 5'd31) shreg_n = {shreg[FRAME_BITS-2:0], 1'b0};
      end
      HOLD: begin
        shreg_n = '0;
        if (tick) begin
`ifdef DAC_SPI_LDAC_EN
          state_n = LDAC;
          lcnt_n  = '0;
`else
          state_n = IDLE;
`endif
        end
      end
      LDAC: begin
        shreg_n = '0;
`ifdef DAC_SPI_LDAC_EN
        if (lcnt == LDAC_LAST) begin
          state_n = IDLE;
          lcnt_n  = '0;
        end else begin
          lcnt_n = lcnt + 4'd1;
        end
`else
        state_n = IDLE;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ecnt     <= '0;
      shreg    <= '0;
      s_ready  <= 1'b0;
      dac_cs_n <= 1'b1;
    end else begin
      state    <= state_n;
      ecnt     <= ecnt_n;
      shreg    <= shreg_n;
      s_ready  <= (state_n == IDLE);
      dac_cs_n <= (state_n != SHIFT);
    end
  end

`ifdef DAC_SPI_LDAC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt       <= '0;
      dac_ldac_n <= 1'b1;
    end else begin
      lcnt       <= lcnt_n;
      dac_ldac_n <= (state_n != LDAC);
    end
  end

  assign frame_done = (state == LDAC) && (lcnt == LDAC_LAST);
`else
  assign dac_ldac_n = 1'b0;
  assign frame_done = (state == HOLD) && tick;
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// Self-checking bench for dac_spi_tx: one instance with CLK_DIV=2 and one
// with CLK_DIV=1, selected through a shared stimulus/observation mux.
module tb_dac_spi_tx;

`ifdef DAC_SPI_LDAC_EN
  localparam int  L_EFF      = 2;
  localparam bit  LDAC_BUILD = 1'b1;
`else
  localparam int  L_EFF      = 0;
  localparam bit  LDAC_BUILD = 1'b0;
`endif
  localparam logic [3:0] CFG = 4'b0011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        s_valid = 1'b0;
  logic [11:0] s_data = '0;

  logic ready0, cs0, sclk0, mosi0, ldac0, done0;
  logic ready1, cs1, sclk1, mosi1, ldac1, done1;
  logic ready, cs, sclk, mosi, ldac, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dac_spi_tx #(.CLK_DIV(2), .AMP_WIDTH(12), .CFG_BITS(CFG), .LDAC_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid && !sel),
    .s_ready(ready0), .dac_cs_n(cs0), .dac_sclk(sclk0), .dac_mosi(mosi0),
    .dac_ldac_n(ldac0), .frame_done(done0));

  dac_spi_tx #(.CLK_DIV(1), .AMP_WIDTH(12), .CFG_BITS(CFG), .LDAC_CYCLES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid && sel),
    .s_ready(ready1), .dac_cs_n(cs1), .dac_sclk(sclk1), .dac_mosi(mosi1),
    .dac_ldac_n(ldac1), .frame_done(done1));

  assign ready = sel ? ready1 : ready0;
  assign cs    = sel ? cs1    : cs0;
  assign sclk  = sel ? sclk1  : sclk0;
  assign mosi  = sel ? mosi1  : mosi0;
  assign ldac  = sel ? ldac1  : ldac0;
  assign done  = sel ? done1  : done0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Sends one sample on the selected instance and checks the whole frame
  // against the expected waveform. keep_valid leaves s_valid high with
  // next_data after accept. abort_at > 0 pulses reset at that SCLK rise.
  task automatic frame(input logic [11:0] data, input bit keep_valid,
                       input logic [11:0] next_data, input int abort_at);
    int d, per, n, rises, cs_low, ldac_low, dones, done_n, mosi_bad, first_rise, stray;
    logic [15:0] cap;
    logic psclk, pmosi;
    d = sel ? 1 : 2;
    per = 1 + 33 * d + L_EFF;
    rises = 0; cs_low = 0; ldac_low = 0; dones = 0; done_n = -1;
    mosi_bad = 0; first_rise = -1; stray = 0; cap = '0;

    n = 0;
    while (!ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      chk("ready_wait", 32'd0, 32'd1);
      return;
    end

    s_data = data;
    s_valid = 1'b1;
    psclk = sclk;
    pmosi = mosi;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        if (keep_valid) s_data = next_data;
        else begin
          s_valid = 1'b0;
          s_data = 12'($urandom);
        end
      end
      if (!cs) cs_low++;
      if (!ldac) ldac_low++;
      if (done) begin
        dones++;
        done_n = n;
      end
      if (sclk && !psclk) begin
        rises++;
        cap = {cap[14:0], mosi};
        if (rises == 1) first_rise = n;
        if (cs) stray++;
      end
      if (mosi !== pmosi && sclk) mosi_bad++;
      psclk = sclk;
      pmosi = mosi;

      if (abort_at != 0 && rises == abort_at) begin
        chk("done_before_abort", dones, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_cs_n", cs, 1);
        chk("abort_sclk", sclk, 0);
        chk("abort_mosi", mosi, 0);
        chk("abort_ldac_n", ldac, LDAC_BUILD);
        chk("abort_ready", ready, 0);
        dones = 0;
        repeat (4) begin
          @(negedge clk);
          if (done) dones++;
          if (LDAC_BUILD && !ldac) dones++;
        end
        chk("abort_no_done_no_ldac", dones, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready_after_release", ready, 1);
        return;
      end
      if (ready || n >= 2000) break;
    end

    chk("period", n, per);
    chk("frame_bits", cap, {CFG, data});
    chk("sclk_rises", rises, 16);
    chk("first_rise_pos", first_rise, d + 1);
    chk("cs_low_cycles", cs_low, 32 * d);
    chk("ldac_low_cycles", ldac_low, LDAC_BUILD ? L_EFF : n);
    chk("done_count", dones, 1);
    chk("done_pos", done_n, per - 1);
    chk("mosi_change_while_sclk_high", mosi_bad, 0);
    chk("sclk_rise_cs_high", stray, 0);
  endtask

  initial begin : main
    logic [11:0] dv, nd;
    bit kv;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready0", ready0, 0);
    chk("rst_cs0", cs0, 1);
    chk("rst_sclk0", sclk0, 0);
    chk("rst_mosi0", mosi0, 0);
    chk("rst_ldac0", ldac0, LDAC_BUILD);
    chk("rst_done0", done0, 0);
    chk("rst_ready1", ready1, 0);
    chk("rst_cs1", cs1, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release0", ready0, 1);
    chk("ready_after_release1", ready1, 1);
    repeat (3) @(negedge clk);
    chk("idle_pins", {cs0, sclk0, mosi0, ldac0}, {1'b1, 1'b0, 1'b0, LDAC_BUILD});

    // CLK_DIV=2 instance
    sel = 1'b0;
    frame(12'hA5C, 1'b0, 12'h000, 0);
    frame(12'h000, 1'b1, 12'hFFF, 0);
    frame(12'hFFF, 1'b0, 12'h000, 0);
    frame(12'($urandom), 1'b0, 12'h000, 10);
    frame(12'h5A3, 1'b0, 12'h000, 0);
    dv = 12'($urandom);
    for (int i = 0; i < 6; i++) begin
      kv = (i < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      nd = 12'($urandom);
      frame(dv, kv, nd, 0);
      dv = kv ? nd : 12'($urandom);
    end

    // CLK_DIV=1 instance
    s_valid = 1'b0;
    @(negedge clk);
    sel = 1'b1;
    frame(12'hA5C, 1'b0, 12'h000, 0);
    dv = 12'($urandom);
    for (int i = 0; i < 4; i++) begin
      kv = (i < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      nd = 12'($urandom);
      frame(dv, kv, nd, 0);
      dv = kv ? nd : 12'($urandom);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_spi_tx.md
DAC_SPI_TX -- requirements
Module: dac_spi_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: SCLK half-period in clk cycles; legal range 1..255.
REQ-002 SHALL have parameter AMP_WIDTH, default 12: sample width, right-justified in the frame.
REQ-003 SHALL have parameter CFG_BITS, default 4'b0011: frame bits [15:12] (channel A, unbuffered, gain 1x, active).
REQ-004 SHALL have parameter LDAC_CYCLES, default 2: width of the ldac_n low pulse in clk cycles; legal range 1..15.
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port s_data, input, AMP_WIDTH: sample from the DDS core.
REQ-008 SHALL have port s_valid, input, 1: s_data is valid.
REQ-009 SHALL have port s_ready, output, 1: the block accepts a sample this cycle.
REQ-010 SHALL have port dac_cs_n, output, 1: DAC chip select, active-low.
REQ-011 SHALL have port dac_sclk, output, 1: SPI clock, mode 0.
REQ-012 SHALL have port dac_mosi, output, 1: serial data, MSB first.
REQ-013 SHALL have port dac_ldac_n, output, 1: DAC latch strobe, active-low.
REQ-014 SHALL have port frame_done, output, 1: one-cycle pulse when a frame completes.

Function
REQ-015 SHALL accept a sample on the rising clk edge where s_valid and s_ready are both high, and latch the frame {CFG_BITS, s_data} into a 16-bit shift register.
REQ-016 SHALL drive s_ready high only in state IDLE, as a registered output with no combinational path from s_valid.
REQ-017 SHALL use the states IDLE, SHIFT, HOLD and LDAC, with transitions IDLE->SHIFT on accept, SHIFT->HOLD after 32*CLK_DIV cycles, HOLD->LDAC after CLK_DIV cycles, and LDAC->IDLE after LDAC_CYCLES cycles.
REQ-018 SHALL, in SHIFT, drive dac_cs_n low starting the cycle after accept, present bit 15 on dac_mosi, and hold dac_sclk low for the first CLK_DIV cycles.
REQ-019 SHALL toggle dac_sclk every CLK_DIV cycles, producing exactly 16 rising edges per frame.
REQ-020 SHALL change dac_mosi only on SCLK falling edges, so that data is stable for CLK_DIV cycles on each side of every rising edge.
REQ-021 SHALL, on entry to HOLD, drive dac_cs_n high and dac_sclk low together, and then drive dac_mosi low.
REQ-022 SHALL drive dac_ldac_n low for exactly LDAC_CYCLES cycles in state LDAC, and assert frame_done in the final LDAC cycle.
REQ-023 SHALL ignore s_data and s_valid outside IDLE; a sample held valid through a frame is accepted on the first IDLE cycle.
REQ-024 SHALL have a frame period, accept to next s_ready high, of 1 + 32*CLK_DIV + CLK_DIV + LDAC_CYCLES cycles.
REQ-025 SHALL, when s_valid is low in IDLE, keep all DAC pins idle (cs_n=1, sclk=0, mosi=0, ldac_n=1), so the DAC holds its last value.
REQ-026 SHALL use an 8-bit half-period counter and a 5-bit edge counter that never wrap mid-frame, with the edge counter reaching 31 exactly at the end of SHIFT.

Reset
REQ-027 SHALL, while rst_n is low, force state IDLE, s_ready=0, dac_cs_n=1, dac_sclk=0, dac_mosi=0, dac_ldac_n=1, frame_done=0, and clear all counters and the shift register.
REQ-028 SHALL, on reset assertion mid-frame, abort the frame immediately with no ldac_n pulse and no frame_done.
REQ-029 SHALL raise s_ready on the first clk edge after rst_n deasserts.

Configuration
REQ-030 SHALL, with macro DAC_SPI_LDAC_EN defined, implement the LDAC state and the ldac_n pulse as specified in REQ-017 and REQ-022.
REQ-031 SHALL, without DAC_SPI_LDAC_EN, omit the LDAC state, hold dac_ldac_n permanently low so the DAC latches on the cs_n rising edge, and assert frame_done in the final HOLD cycle; the frame period then becomes 1 + 33*CLK_DIV.

Structure
REQ-032 SHALL place the state enum (IDLE, SHIFT, HOLD, LDAC), FRAME_BITS=16 and the CFG_BITS field constants (A/B, BUF, GA, SHDN) in package dac_spi_pkg.
REQ-033 SHALL implement SCLK generation (half-period counter plus rise/fall strobes) in the sub-module dac_sclk_gen, instantiated once.

Verification
REQ-034 SHALL cover a single sample: CLK_DIV=2, s_data=12'hA5C -> MOSI captured on SCLK rises is 16'h3A5C, 16 rises, cs_n low for 64 cycles, ldac_n low for 2 cycles, s_ready high again 69 cycles after accept.
REQ-035 SHALL cover back-to-back samples: s_valid held high with 12'h000 then 12'hFFF -> frames 16'h3000 and 16'h3FFF, exactly 69-cycle spacing, no extra SCLK edges between frames.
REQ-036 SHALL cover reset mid-frame: rst_n pulsed low at the 10th SCLK rise -> cs_n=1, sclk=0 and ldac_n=1 in the same cycle, no frame_done, next frame complete and correct.
REQ-037 SHALL cover CLK_DIV=1 -> SCLK = clk/2, 16 rises, frame period 36 cycles, and MOSI never changes on an SCLK rise.
REQ-038 SHALL cover a build without DAC_SPI_LDAC_EN -> ldac_n constantly 0, frame_done in the final HOLD cycle, period 1+33*CLK_DIV.
REQ-039 SHALL cover s_data changing while s_ready is low -> the transmitted frame equals the value latched at accept.
